// File: rtl/bingo_pkg.sv
// Types and constants shared between the Bingo prefetcher and the
// lower-level-cache prefetch queue.
package bingo_pkg;

  localparam int unsigned WORD_WIDTH   = 64;
  localparam int unsigned BLOCK_OFFSET = 6;

  typedef logic [WORD_WIDTH-1:0] bingo_word;

  typedef struct packed {
    logic      valid;
    bingo_word blk;
  } pf_entry_t;

endpackage

// File: rtl/pf_queue_cam.sv
// CAM-searchable circular FIFO of block numbers: match lookup, demand
// invalidate-by-match, push at tail and pop at head.
module pf_queue_cam
  import bingo_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  bingo_word                    lookup_blk,
  output logic [DEPTH-1:0]             lookup_match,
  input  logic                         inv_en,
  input  bingo_word                    inv_blk,
  output logic                         inv_hit,
  input  logic                         push,
  input  bingo_word                    push_blk,
  input  logic                         pop,
  output pf_entry_t                    head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  pf_entry_t        entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] inv_match;

  always_comb begin
    lookup_match = '0;
    inv_match    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lookup_match[i] = entries[i].valid && (entries[i].blk == lookup_blk);
      inv_match[i]    = entries[i].valid && (entries[i].blk == inv_blk);
    end
    inv_hit    = inv_en && (|inv_match);
    head_entry = entries[head];
  end

  // Popped slots are cleared so lookups only ever see live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (inv_en && inv_match[i]) entries[i].valid <= 1'b0;
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (push) begin
        entries[tail].valid <= 1'b1;
        entries[tail].blk   <= push_blk;
        tail                <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bingo_prefetch_queue.sv
// Prefetch request queue: dedups incoming block prefetches, cancels those
// colliding with demand misses, and issues survivors to memory in FIFO order.
module bingo_prefetch_queue
  import bingo_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BLOCK_OFFSET = bingo_pkg::BLOCK_OFFSET,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     pf_address_i,
  input  logic                 pf_valid_i,
  output logic                 pf_ready_o,
  input  logic                 demand_valid_i,
  input  logic [WIDTH-1:0]     demand_address_i,
  output logic [WIDTH-1:0]     mem_address_o,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [CNT_WIDTH-1:0] drop_count_o,
  output logic [CNT_WIDTH-1:0] issue_count_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  bingo_word        in_blk;
  bingo_word        dem_blk;
  bingo_word        out_blk;
  logic [DEPTH-1:0] q_match;
  logic             cancel_hit;
  pf_entry_t        head_entry;
  logic [CW-1:0]    count;
  logic             dup, accept, push, dup_drop;
  logic             complete, out_free, load, pop;
  logic [1:0]       drop_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign in_blk  = bingo_word'(pf_address_i >> BLOCK_OFFSET);
  assign dem_blk = bingo_word'(demand_address_i >> BLOCK_OFFSET);
  assign out_blk = bingo_word'(mem_address_o >> BLOCK_OFFSET);

  pf_queue_cam #(.DEPTH(DEPTH)) u_cam (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_blk   (in_blk),
    .lookup_match (q_match),
    .inv_en       (demand_valid_i),
    .inv_blk      (dem_blk),
    .inv_hit      (cancel_hit),
    .push         (push),
    .push_blk     (in_blk),
    .pop          (pop),
    .head_entry   (head_entry),
    .count        (count)
  );

  always_comb begin
    pf_ready_o = (count != CW'(DEPTH));
    dup        = (|q_match)
               || (mem_valid_o && (out_blk == in_blk))
               || (demand_valid_i && (dem_blk == in_blk));
    accept     = pf_valid_i && pf_ready_o;
    push       = accept && !dup;
    dup_drop   = accept && dup;
    complete   = mem_valid_o && mem_ready_i;
    out_free   = !mem_valid_o || mem_ready_i;
    // A cancelled head is skipped even while demand traffic blocks loads.
    load       = (count != '0) && head_entry.valid && out_free && !demand_valid_i;
    pop        = ((count != '0) && !head_entry.valid) || load;
    drop_inc   = {1'b0, dup_drop} + {1'b0, cancel_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_o   <= 1'b0;
      mem_address_o <= '0;
      drop_count_o  <= '0;
      issue_count_o <= '0;
    end else begin
      if (load) begin
        mem_valid_o   <= 1'b1;
        mem_address_o <= WIDTH'(head_entry.blk << BLOCK_OFFSET);
      end else if (complete) begin
        mem_valid_o   <= 1'b0;
      end
      drop_count_o  <= sat_add(drop_count_o, drop_inc);
      issue_count_o <= sat_add(issue_count_o, {1'b0, complete});
    end
  end

endmodule

// File: tb/tb_bingo_prefetch_queue.sv
// Directed scoreboard bench for bingo_prefetch_queue.
module tb_bingo_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pf_address_i;
  logic        pf_valid_i;
  logic        pf_ready_o;
  logic        demand_valid_i;
  logic [63:0] demand_address_i;
  logic [63:0] mem_address_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [15:0] drop_count_o;
  logic [15:0] issue_count_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] prev_addr  = '0;

  always #5 clk = ~clk;

  bingo_prefetch_queue #(
    .WIDTH(64), .DEPTH(8), .BLOCK_OFFSET(6), .CNT_WIDTH(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pf_address_i     (pf_address_i),
    .pf_valid_i       (pf_valid_i),
    .pf_ready_o       (pf_ready_o),
    .demand_valid_i   (demand_valid_i),
    .demand_address_i (demand_address_i),
    .mem_address_o    (mem_address_o),
    .mem_valid_o      (mem_valid_o),
    .mem_ready_i      (mem_ready_i),
    .drop_count_o     (drop_count_o),
    .issue_count_o    (issue_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge: completions pop the scoreboard, stalls must hold.
  task automatic tick();
    @(negedge clk);
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", {63'b0, mem_valid_o}, 64'd1);
      chk("hold_addr", mem_address_o, prev_addr);
    end
    if (mem_valid_o && mem_ready_i) begin
      if (exp_q.size() == 0) chk("spurious_issue", mem_address_o, 64'hffff_ffff_ffff_ffff);
      else chk("issue_addr", mem_address_o, exp_q.pop_front());
    end
    prev_valid = mem_valid_o;
    prev_ready = mem_ready_i;
    prev_addr  = mem_address_o;
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [63:0] addr, input bit expect_issue);
    int unsigned budget;
    pf_valid_i   = 1'b1;
    pf_address_i = addr;
    budget = 100;
    while (!pf_ready_o && budget > 0) begin
      tick();
      budget--;
    end
    if (!pf_ready_o) chk("push_wait_timeout", {63'b0, pf_ready_o}, 64'd1);
    if (expect_issue) exp_q.push_back(addr & ~64'h3f);
    tick();
    pf_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned budget;
    mem_ready_i = 1'b1;
    budget = 200;
    while ((exp_q.size() != 0 || mem_valid_o) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; pf_valid_i = 1'b0; pf_address_i = '0;
    demand_valid_i = 1'b0; demand_address_i = '0; mem_ready_i = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_ready", {63'b0, pf_ready_o}, 64'd1);
    chk("rst_mvalid", {63'b0, mem_valid_o}, 64'd0);
    chk("rst_maddr", mem_address_o, 64'd0);
    chk("rst_drop", 64'(drop_count_o), 64'd0);
    chk("rst_issue", 64'(issue_count_o), 64'd0);

    // Basic flow and latency.
    mem_ready_i = 1'b1;
    pf_valid_i = 1'b1; pf_address_i = 64'h1040; exp_q.push_back(64'h1040);
    tick();
    chk("lat_not_yet", {63'b0, mem_valid_o}, 64'd0);
    pf_address_i = 64'h2000; exp_q.push_back(64'h2000);
    tick();
    chk("lat_valid", {63'b0, mem_valid_o}, 64'd1);
    chk("lat_addr", mem_address_o, 64'h1040);
    pf_address_i = 64'h3008; exp_q.push_back(64'h3000);
    tick();
    pf_valid_i = 1'b0;
    drain();
    chk("t1_issue", 64'(issue_count_o), 64'd3);
    chk("t1_drop", 64'(drop_count_o), 64'd0);

    // Duplicate of a queued block.
    push_req(64'h1000, 1'b1);
    push_req(64'h1010, 1'b0);
    drain();
    chk("t2_drop", 64'(drop_count_o), 64'd1);
    chk("t2_issue", 64'(issue_count_o), 64'd4);

    // Fill to full behind a stalled output.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_req(64'h8000 + 64'(i) * 64'h100, 1'b1);
      chk("t3_ready", {63'b0, pf_ready_o}, (i == 8) ? 64'd0 : 64'd1);
    end
    chk("t3_head_addr", mem_address_o, 64'h8000);
    tick(); tick();
    chk("t3_still_full", {63'b0, pf_ready_o}, 64'd0);
    drain();
    chk("t3_issue", 64'(issue_count_o), 64'd13);

    // Demand cancel of a queued entry.
    mem_ready_i = 1'b0;
    push_req(64'h4000, 1'b1);
    push_req(64'h5000, 1'b0);
    push_req(64'h6000, 1'b1);
    demand_valid_i = 1'b1; demand_address_i = 64'h5020;
    tick();
    demand_valid_i = 1'b0;
    chk("t4_drop", 64'(drop_count_o), 64'd2);
    drain();
    chk("t4_issue", 64'(issue_count_o), 64'd15);

    // Demand blocks new loads but not a presented request.
    mem_ready_i = 1'b0;
    push_req(64'h20000, 1'b1);
    push_req(64'h21000, 1'b1);
    push_req(64'h22000, 1'b1);
    push_req(64'h23000, 1'b1);
    demand_valid_i = 1'b1; demand_address_i = 64'hF0000; mem_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_blocked", {63'b0, mem_valid_o}, 64'd0);
      tick();
    end
    chk("t5_issue_mid", 64'(issue_count_o), 64'd16);
    demand_valid_i = 1'b0;
    drain();
    chk("t5_issue", 64'(issue_count_o), 64'd19);
    chk("t5_drop", 64'(drop_count_o), 64'd2);

    // Duplicate drop and cancel in one cycle add two.
    mem_ready_i = 1'b0;
    push_req(64'hA000, 1'b1);
    push_req(64'hB000, 1'b0);
    pf_valid_i = 1'b1; pf_address_i = 64'hB000;
    demand_valid_i = 1'b1; demand_address_i = 64'hB000;
    tick();
    pf_valid_i = 1'b0; demand_valid_i = 1'b0;
    chk("t6_drop", 64'(drop_count_o), 64'd4);
    drain();
    chk("t6_issue", 64'(issue_count_o), 64'd20);

    // Asynchronous reset mid-issue.
    mem_ready_i = 1'b0;
    push_req(64'hC000, 1'b1);
    push_req(64'hD000, 1'b1);
    chk("t7_presented", {63'b0, mem_valid_o}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_mvalid", {63'b0, mem_valid_o}, 64'd0);
    chk("t7_maddr", mem_address_o, 64'd0);
    chk("t7_drop", 64'(drop_count_o), 64'd0);
    chk("t7_issue", 64'(issue_count_o), 64'd0);
    exp_q.delete();
    prev_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t7_ready", {63'b0, pf_ready_o}, 64'd1);
    mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    push_req(64'hE000, 1'b1);
    drain();
    chk("t7_post_issue", 64'(issue_count_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
